ttl_555_meter: RTL

- Receive-side companion to the astable 555 emulation.
- Samples a square wave (555 output, or any board-level oscillator/clock line) and measures each period's high and low durations in clk cycles.
- Publishes both durations with a one-cycle valid strobe.
- Used to verify timer parameters in sim, and at runtime to detect sound/blink oscillators stopping.

---
 rtl/ttl_555_meter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ttl_555_meter.sv
// Square-wave period meter: measures the high and low durations of an asynchronous
// input in clk cycles. Define TTL_555_METER_PERIOD_EN to add the period/duty_high outputs.
module ttl_555_meter #(
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_COUNTS = 65535,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in,
  output logic [CNT_WIDTH-1:0] high_count,
  output logic [CNT_WIDTH-1:0] low_count,
  output logic                 valid,
`ifdef TTL_555_METER_PERIOD_EN
  output logic [CNT_WIDTH:0]   period,
  output logic                 duty_high,
`endif
  output logic                 timeout
);

  typedef enum logic [1:0] {
    WAIT_LOW,
    WAIT_RISE,
    MEAS_HIGH,
    MEAS_LOW
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(TIMEOUT_COUNTS);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] filled_q;
  logic                   p_q;
  logic [CNT_WIDTH-1:0]   counter_q;
  logic [CNT_WIDTH-1:0]   high_len_q;

  logic s, rise, fall, primed, at_limit;
  logic start_cnt, inc_cnt, take_high, publish, expire;

  assign s        = sync_q[SYNC_STAGES-1];
  assign rise     = s & ~p_q;
  assign fall     = ~s & p_q;
  assign at_limit = (counter_q == LIMIT);
  // s only reflects the real input once the reset zeros have drained out of the chain,
  // so a level held high across reset is not mistaken for a fresh low-to-high edge.
  assign primed   = filled_q[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      filled_q <= '0;
      p_q      <= 1'b0;
      state_q  <= WAIT_LOW;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], in};
      filled_q <= {filled_q[SYNC_STAGES-2:0], 1'b1};
      p_q      <= s;
      state_q  <= state_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_LOW:  if (primed && !s) state_d = WAIT_RISE;
      WAIT_RISE: if (rise)         state_d = MEAS_HIGH;
      MEAS_HIGH: begin
        if (fall)          state_d = MEAS_LOW;
        else if (at_limit) state_d = WAIT_LOW;
      end
      MEAS_LOW: begin
        if (rise)          state_d = MEAS_HIGH;
        else if (at_limit) state_d = WAIT_LOW;
      end
      default: state_d = WAIT_LOW;
    endcase
  end

  always_comb begin
    start_cnt = 1'b0;
    inc_cnt   = 1'b0;
    take_high = 1'b0;
    publish   = 1'b0;
    expire    = 1'b0;
    unique case (state_q)
      WAIT_RISE: start_cnt = rise;
      MEAS_HIGH: begin
        if (fall) begin
          take_high = 1'b1;
          start_cnt = 1'b1;
        end else if (at_limit) begin
          expire = 1'b1;
        end else begin
          inc_cnt = 1'b1;
        end
      end
      MEAS_LOW: begin
        // An edge on the limit cycle still completes the measurement.
        if (rise) begin
          publish   = 1'b1;
          start_cnt = 1'b1;
        end else if (at_limit) begin
          expire = 1'b1;
        end else begin
          inc_cnt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter_q  <= '0;
      high_len_q <= '0;
      high_count <= '0;
      low_count  <= '0;
      valid      <= 1'b0;
      timeout    <= 1'b0;
`ifdef TTL_555_METER_PERIOD_EN
      period     <= '0;
      duty_high  <= 1'b0;
`endif
    end else begin
      valid <= publish;
      if (start_cnt)    counter_q <= CNT_WIDTH'(1);
      else if (inc_cnt) counter_q <= counter_q + CNT_WIDTH'(1);
      if (take_high) high_len_q <= counter_q;
      if (publish) begin
        high_count <= high_len_q;
        low_count  <= counter_q;
        timeout    <= 1'b0;
`ifdef TTL_555_METER_PERIOD_EN
        period     <= {1'b0, high_len_q} + {1'b0, counter_q};
        duty_high  <= (high_len_q > counter_q);
`endif
      end else if (expire) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule
